// File: rtl/apb_multi_region_slave.sv
// apb_multi_region_slave: APB4 completer with decoded register regions, wait states, strobes and PSLVERR
module apb_multi_region_slave #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 16,
  parameter int NUM_SLAVES = 4,
  parameter int DEPTH = 16,
  parameter int WAIT_CYCLES = 0,
  parameter logic [NUM_SLAVES-1:0] SLAVE_MASK = {NUM_SLAVES{1'b1}}
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [ADDR_W-1:0] PADDR,
  input  logic [DATA_W-1:0] PWDATA,
  input  logic [DATA_W/8-1:0] PSTRB,
  output logic [DATA_W-1:0] PRDATA,
  output logic              PREADY,
  output logic              PSLVERR
);
  localparam int SB = DATA_W / 8;
  localparam int BB = $clog2(SB);
  localparam int WI = $clog2(DEPTH);
  localparam int RB = $clog2(NUM_SLAVES);
  localparam logic [ADDR_W-1:0] GAP_MASK = ({ADDR_W{1'b1}} >> (RB + BB + WI)) << (BB + WI);
  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
  state_t state_q, state_d, first_state;
  logic [3:0] cnt_q, cnt_d;
  logic [RB-1:0] rgn, rgn_q;
  logic [WI-1:0] idx, idx_q;
  logic err, err_q, write_q, setup, wr_en;
  logic [DATA_W-1:0] wdata_q;
  logic [SB-1:0] strb_q;
  logic [DATA_W-1:0] rd_word [NUM_SLAVES];
  assign rgn = PADDR[ADDR_W-1 -: RB];
  assign idx = PADDR[BB +: WI];
  assign err = !SLAVE_MASK[rgn] || (|PADDR[BB-1:0]) || (|(PADDR & GAP_MASK));
  assign setup = PSEL && !PENABLE;
  assign first_state = (WAIT_CYCLES == 0) ? DONE : WAIT;
  assign wr_en = (state_q == DONE) && PSEL && PENABLE && write_q && !err_q;
  assign PREADY = (state_q == DONE);
  assign PSLVERR = (state_q == DONE) && err_q;
  always_comb begin
    state_d = IDLE;
    cnt_d = cnt_q;
    state_d = setup ? first_state :
              (state_q == WAIT && PSEL && cnt_q == 4'd1) ? DONE :
              (state_q == WAIT && PSEL) ? WAIT : IDLE;
    cnt_d = setup ? 4'(WAIT_CYCLES) :
            (state_q == WAIT && PSEL && PENABLE) ? cnt_q - 4'd1 : cnt_q;
  end
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q <= IDLE;
      cnt_q <= '0;
      PRDATA <= '0;
      rgn_q <= '0;
      idx_q <= '0;
      err_q <= 1'b0;
      write_q <= 1'b0;
      wdata_q <= '0;
      strb_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      if (setup) begin
        rgn_q <= rgn;
        idx_q <= idx;
        err_q <= err;
        write_q <= PWRITE;
        wdata_q <= PWDATA;
        strb_q <= PSTRB;
        PRDATA <= (!PWRITE && !err) ? rd_word[rgn] : '0;
      end
    end
  end
  // Unimplemented regions get no storage and read back as zero.
  for (genvar r = 0; r < NUM_SLAVES; r++) begin : g_reg
    if (SLAVE_MASK[r]) begin : g_mem
      logic [DATA_W-1:0] mem [DEPTH];
      always_ff @(posedge PCLK) begin
        if (PRESET) begin
          for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (wr_en && rgn_q == RB'(r)) begin
          for (int j = 0; j < SB; j++) if (strb_q[j]) mem[idx_q][8*j +: 8] <= wdata_q[8*j +: 8];
        end
      end
      assign rd_word[r] = mem[idx];
    end else begin : g_none
      assign rd_word[r] = '0;
    end
  end
endmodule

// File: tb/tb_apb_multi_region_slave.sv
// tb_apb_multi_region_slave: directed checks on a zero-wait masked instance and a 3-wait full instance
module tb_apb_multi_region_slave;
  logic clk = 0;
  logic rst, psel, penable, pwrite, use_b;
  logic [15:0] paddr;
  logic [31:0] pwdata, prdata_a, prdata_b;
  logic [3:0] pstrb;
  logic pready_a, pready_b, pslverr_a, pslverr_b;
  int checks = 0, failures = 0;
  logic [31:0] rd;
  logic er;
  int cyc;
  always #5 clk = ~clk;
  apb_multi_region_slave #(.WAIT_CYCLES(0), .SLAVE_MASK(4'b0111)) dut_a (
    .PCLK(clk), .PRESET(rst), .PSEL(psel && !use_b), .PENABLE(penable), .PWRITE(pwrite),
    .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb), .PRDATA(prdata_a), .PREADY(pready_a), .PSLVERR(pslverr_a));
  apb_multi_region_slave #(.WAIT_CYCLES(3)) dut_b (
    .PCLK(clk), .PRESET(rst), .PSEL(psel && use_b), .PENABLE(penable), .PWRITE(pwrite),
    .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb), .PRDATA(prdata_b), .PREADY(pready_b), .PSLVERR(pslverr_b));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic xfer(input logic wr, input logic [15:0] a, input logic [31:0] d, input logic [3:0] s,
                      output logic [31:0] rdata, output logic err, output int n);
    logic done;
    psel = 1; penable = 0; pwrite = wr; paddr = a; pwdata = d; pstrb = s;
    @(posedge clk); #1;
    penable = 1; n = 1; done = 0; rdata = 'x; err = 1'bx;
    while (!done && n < 40) begin
      n++;
      if (use_b ? pready_b : pready_a) begin
        rdata = use_b ? prdata_b : prdata_a;
        err = use_b ? pslverr_b : pslverr_a;
        done = 1;
      end
      @(posedge clk); #1;
    end
    psel = 0; penable = 0;
    if (!done) chk("timeout", 32'(n), 32'hFFFF_FFFF);
  endtask
  initial begin
    rst = 1; psel = 0; penable = 0; pwrite = 0; paddr = 0; pwdata = 0; pstrb = 0; use_b = 0;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    chk("rst_pready", 32'(pready_a), 0);
    chk("rst_pslverr", 32'(pslverr_a), 0);
    chk("rst_prdata", prdata_a, 0);
    xfer(1, 16'h0004, 32'hDEADBEEF, 4'hF, rd, er, cyc);
    chk("wr4_cyc", 32'(cyc), 2); chk("wr4_err", 32'(er), 0);
    xfer(0, 16'h0004, 0, 4'h0, rd, er, cyc);
    chk("rd4_cyc", 32'(cyc), 2); chk("rd4_data", rd, 32'hDEADBEEF); chk("rd4_err", 32'(er), 0);
    xfer(1, 16'h8008, 32'h11223344, 4'hF, rd, er, cyc);
    xfer(1, 16'h8008, 32'hAABBCCDD, 4'h5, rd, er, cyc);
    xfer(0, 16'h8008, 0, 4'h0, rd, er, cyc);
    chk("strb_data", rd, 32'h11BB33DD);
    xfer(1, 16'hC000, 32'h12345678, 4'hF, rd, er, cyc);
    chk("unimpl_wr_err", 32'(er), 1);
    xfer(0, 16'hC000, 0, 4'h0, rd, er, cyc);
    chk("unimpl_rd_err", 32'(er), 1); chk("unimpl_rd_data", rd, 0);
    xfer(1, 16'h0002, 32'hFFFFFFFF, 4'hF, rd, er, cyc);
    chk("misalign_wr_err", 32'(er), 1);
    xfer(1, 16'h0040, 32'hFFFFFFFF, 4'hF, rd, er, cyc);
    chk("gap_wr_err", 32'(er), 1);
    xfer(0, 16'h0000, 0, 4'h0, rd, er, cyc);
    chk("err_nowrite", rd, 0); chk("word0_err", 32'(er), 0);
    xfer(0, 16'h0004, 0, 4'h0, rd, er, cyc);
    xfer(0, 16'h0002, 0, 4'h0, rd, er, cyc);
    chk("misalign_rd_err", 32'(er), 1); chk("misalign_rd_data", rd, 0);
    xfer(0, 16'h0040, 0, 4'h0, rd, er, cyc);
    chk("gap_rd_err", 32'(er), 1);
    xfer(1, 16'h0004, 32'h0, 4'h0, rd, er, cyc);
    chk("strb0_err", 32'(er), 0);
    xfer(0, 16'h0004, 0, 4'h0, rd, er, cyc);
    chk("strb0_keep", rd, 32'hDEADBEEF);
    xfer(0, 16'h0000, 0, 4'h0, rd, er, cyc);
    chk("b2b_a0", rd, 0); chk("b2b_a0_cyc", 32'(cyc), 2);
    xfer(0, 16'h8008, 0, 4'h0, rd, er, cyc);
    chk("b2b_a1", rd, 32'h11BB33DD);
    use_b = 1;
    xfer(1, 16'h4000, 32'hCAFEF00D, 4'hF, rd, er, cyc);
    chk("w3_wr_cyc", 32'(cyc), 5);
    xfer(0, 16'h4000, 0, 4'h0, rd, er, cyc);
    chk("w3_rd_cyc", 32'(cyc), 5); chk("w3_rd_data", rd, 32'hCAFEF00D); chk("w3_rd_err", 32'(er), 0);
    psel = 1; penable = 0; pwrite = 1; paddr = 16'h4004; pwdata = 32'h99999999; pstrb = 4'hF;
    @(posedge clk); #1 penable = 1;
    chk("abort_wait0", 32'(pready_b), 0);
    @(posedge clk); #1;
    chk("abort_wait1", 32'(pready_b), 0);
    psel = 0; penable = 0;
    @(posedge clk); #1;
    chk("abort_idle", 32'(pready_b), 0);
    xfer(0, 16'h4004, 0, 4'h0, rd, er, cyc);
    chk("abort_nowrite", rd, 0);
    xfer(1, 16'h0000, 32'h00001234, 4'hF, rd, er, cyc);
    xfer(0, 16'h0000, 0, 4'h0, rd, er, cyc);
    chk("pre_rst_data", rd, 32'h00001234);
    psel = 1; penable = 0; pwrite = 1; paddr = 16'h0000; pwdata = 32'h55555555; pstrb = 4'hF;
    @(posedge clk); #1 penable = 1;
    @(posedge clk); #1 rst = 1;
    @(posedge clk); #1;
    chk("rst_mid_pready", 32'(pready_b), 0);
    rst = 0; psel = 0; penable = 0;
    @(posedge clk); #1;
    xfer(0, 16'h0000, 0, 4'h0, rd, er, cyc);
    chk("rst_cleared", rd, 0);
    xfer(1, 16'h4000, 32'hA5A5A5A5, 4'hF, rd, er, cyc);
    xfer(0, 16'h0000, 0, 4'h0, rd, er, cyc);
    chk("b2b_b0", rd, 0); chk("b2b_b0_cyc", 32'(cyc), 5);
    xfer(0, 16'h4000, 0, 4'h0, rd, er, cyc);
    chk("b2b_b1", rd, 32'hA5A5A5A5); chk("b2b_b1_cyc", 32'(cyc), 5);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/apb_multi_region_slave.md
# apb_multi_region_slave

Parametrised APB4 completer serving `NUM_SLAVES` address-decoded register regions with programmable wait states, byte strobes and `PSLVERR`. It is the next generation of the single-region APB wrapper: it decodes every region instead of only region 0. It reports decode, alignment and range errors instead of silently idling, and it inserts a configurable number of wait states. It sits behind the system APB requester and is driven directly by the APB verification bench.

## Interface
- `DATA_W`, default 32: data bus width; 32 or 64.
- `ADDR_W`, default 16: address width.
- `NUM_SLAVES`, default 4: number of regions; power of 2, ≥2.
- `DEPTH`, default 16: words per region; power of 2.
- `WAIT_CYCLES`, default 0: wait states per transfer, range 0–15.
- `SLAVE_MASK`, default `{NUM_SLAVES{1'b1}}`: bit r=1 means region r is implemented.
- `PCLK`  in  1  clock; all logic on the rising edge.
- `PRESET`  in  1  reset; synchronous, active-high.
- `PSEL`  in  1  select.
- `PENABLE`  in  1  access phase.
- `PWRITE`  in  1  1=write, 0=read.
- `PADDR`  in  `ADDR_W`  byte address.
- `PWDATA`  in  `DATA_W`  write data.
- `PSTRB`  in  `DATA_W/8`  write byte lanes.
- `PRDATA`  out  `DATA_W`  read data; registered.
- `PREADY`  out  1  transfer completes this cycle.
- `PSLVERR`  out  1  error response; valid only while `PREADY`=1.

## Operation
- Address fields:
  - Byte offset: `BB` = log2(`DATA_W`/8) LSBs.
  - Word index: the next log2(`DEPTH`) bits.
  - Region: the top log2(`NUM_SLAVES`) bits. With defaults this is `PADDR[15:14]`.
  - Gap bits: the bits between the word index and the region field.
- A transfer has an error if any of the following holds:
  - Its region has `SLAVE_MASK` bit 0.
  - The byte offset is nonzero.
  - Any gap bit is nonzero.
- Storage: `NUM_SLAVES`×`DEPTH` words of `DATA_W`. Unimplemented regions need no storage.
- FSM states are `IDLE`, `WAIT` and `DONE`.
- `IDLE`:
  - On `PSEL`=1 and `PENABLE`=0, latch address, write, data, strobe and error.
  - Load the counter with `WAIT_CYCLES`.
  - Load `PRDATA` with the addressed word for a good read, or with 0 for a write or an error.
  - Go to `DONE` if `WAIT_CYCLES`=0, else to `WAIT`.
- `WAIT`:
  - With `PSEL`=1 and `PENABLE`=1: decrement the counter. When it reaches 1, go to `DONE`.
  - With `PSEL`=0: abort to `IDLE`; nothing is written.
  - With `PSEL`=1 and `PENABLE`=0: treat as a new SETUP and re-latch as in `IDLE`.
- `DONE`:
  - `PREADY` = 1. `PSLVERR` = the latched error.
  - On the edge with `PSEL`=1 and `PENABLE`=1: a good write updates each byte lane whose `PSTRB` bit is 1 from the latched data. An erroring write changes nothing.
  - Next state is `IDLE`.
  - Abort and re-SETUP rules are the same as in `WAIT`.
- `PREADY` and `PSLVERR` are combinational decodes of state and latched error only; they never depend directly on the bus inputs.
- Reads ignore `PSTRB`. A write with `PSTRB`=0 completes without error and changes nothing.

## Timing
- Reset (`PRESET`=1 at an edge):
  - State goes to `IDLE`, the counter to 0, `PRDATA` to 0.
  - All storage words are cleared to 0.
  - `PREADY`=0 and `PSLVERR`=0 from the cycle after that edge.
  - Reset overrides a pending transfer; its write is discarded.
- Latency:
  - The SETUP cycle is sampled at edge E1.
  - `PREADY` rises in the cycle after E1 + `WAIT_CYCLES` cycles.
  - A transfer occupies 2 + `WAIT_CYCLES` bus cycles.
- Back-to-back: after `DONE` the block is in `IDLE`, so the next SETUP is accepted on the very next edge; no dead cycle is inserted.
- A write committed at edge E is visible to a read whose SETUP is sampled at E+1.
- `PRDATA` holds its value until the next SETUP is sampled.

## Test plan
- Reset, then write 0xDEADBEEF to 0x0004 with `PSTRB`=0xF and `WAIT_CYCLES`=0, then read 0x0004. Required: each transfer takes 2 cycles, `PRDATA`=0xDEADBEEF, `PSLVERR`=0.
- Write 0x11223344 to 0x8008, then write 0xAABBCCDD with `PSTRB`=0x5, then read. Required: `PRDATA`=0x11BB33DD.
- With `SLAVE_MASK`=0b0111, access 0xC000; separately access 0x0002 and 0x0040 (`DEPTH`=16). Required: `PREADY` with `PSLVERR`=1 each time, read `PRDATA`=0, storage unchanged.
- With `WAIT_CYCLES`=3, read 0x4000. Required: `PREADY` low for 3 ACCESS cycles, high on the 4th. Also drop `PSEL` mid-wait on a write. Required: return to `IDLE`, no write.
- Assert `PRESET` during `WAIT` of a write to 0x0000. Required: `PREADY`=0 next cycle, and a later read of 0x0000 returns 0.
- Back-to-back reads of 0x0000 and 0x4000 with no idle cycle between them. Required: both complete, each with correct data, with no dropped SETUP.
